// File: rtl/input_byte_sequencer.sv
// Serialises 32-bit host words into one byte per clock for the ping-pong
// pre-data stage, pulsing a bank switch after every ROW_BYTES bytes.
//
// Ports:
//   din_clk, rst_n (sync, active-low), en (global enable)
//   i_start            start one frame of ROWS rows (sampled in IDLE)
//   i_word/i_word_vld  input word, byte 0 = i_word[7:0] goes out first
//   o_word_rdy         word taken when i_word_vld && o_word_rdy
//   o_data_din/_vld    serial byte stream
//   o_switch_pingpong  one-cycle pulse per completed row
//   o_busy             high outside IDLE
//   o_frame_done       one-cycle pulse at frame end
//   o_row_cnt          completed rows in the current frame
module input_byte_sequencer #(
  parameter int ROW_BYTES = 34,
  parameter int ROWS      = 16
) (
  input  logic                      din_clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      i_start,
  input  logic [31:0]               i_word,
  input  logic                      i_word_vld,
  output logic                      o_word_rdy,
  output logic [7:0]                o_data_din,
  output logic                      o_data_din_vld,
  output logic                      o_switch_pingpong,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic [$clog2(ROWS+1)-1:0] o_row_cnt
);

  localparam int WORDS_TOTAL = (ROW_BYTES * ROWS + 3) / 4;
  localparam int BW = $clog2(ROW_BYTES);
  localparam int RW = $clog2(ROWS + 1);
  localparam int WW = $clog2(WORDS_TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    SWITCH,
    DONE
  } state_t;

  state_t        state;
  logic [31:0]   byte_buf;
  logic [2:0]    buf_cnt;
  logic [BW-1:0] byte_cnt;
  logic [WW-1:0] word_cnt;

  logic emit;
  logic take;
  logic row_end;
  logic last_row;
  logic in_frame;
  logic need_word;
  logic buf_free;

  assign emit     = en && (state == STREAM)
                    && (buf_cnt != 3'd0);
  assign in_frame = (state == STREAM)
                    || (state == SWITCH);
  assign need_word = word_cnt < WW'(WORDS_TOTAL);
  // A new word may land on the same edge the last
  // buffered byte leaves, keeping the stream gapless.
  assign buf_free = (buf_cnt == 3'd0)
                    || ((buf_cnt == 3'd1) && emit);

  assign o_word_rdy = en && in_frame
                      && need_word && buf_free;
  assign take     = o_word_rdy && i_word_vld;
  assign row_end  = byte_cnt == BW'(ROW_BYTES - 1);
  assign last_row = o_row_cnt == RW'(ROWS - 1);

  always_ff @(posedge din_clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      byte_buf          <= '0;
      buf_cnt           <= '0;
      byte_cnt          <= '0;
      word_cnt          <= '0;
      o_data_din        <= 8'h00;
      o_data_din_vld    <= 1'b0;
      o_switch_pingpong <= 1'b0;
      o_busy            <= 1'b0;
      o_frame_done      <= 1'b0;
      o_row_cnt         <= '0;
    end else begin
      o_data_din_vld    <= 1'b0;
      o_switch_pingpong <= 1'b0;
      o_frame_done      <= 1'b0;

      if (take) begin
        byte_buf <= i_word;
        buf_cnt  <= 3'd4;
        word_cnt <= word_cnt + WW'(1);
      end else if (emit) begin
        byte_buf <= {8'h00, byte_buf[31:8]};
        buf_cnt  <= buf_cnt - 3'd1;
      end

      if (emit) begin
        o_data_din     <= byte_buf[7:0];
        o_data_din_vld <= 1'b1;
        byte_cnt       <= byte_cnt + BW'(1);
      end

      if (en) begin
        unique case (state)
          IDLE: begin
            if (i_start) begin
              state     <= STREAM;
              o_busy    <= 1'b1;
              byte_cnt  <= '0;
              word_cnt  <= '0;
              buf_cnt   <= '0;
              o_row_cnt <= '0;
            end else begin
              o_busy <= 1'b0;
            end
          end
          STREAM: begin
            if (emit && row_end) begin
              state <= SWITCH;
            end
          end
          SWITCH: begin
            o_switch_pingpong <= 1'b1;
            o_row_cnt <= o_row_cnt + RW'(1);
            byte_cnt  <= '0;
            state     <= last_row ? DONE : STREAM;
          end
          DONE: begin
            // Tail bytes past the frame are dropped.
            o_frame_done <= 1'b1;
            buf_cnt      <= '0;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_byte_sequencer.sv
// Scoreboard bench for input_byte_sequencer.
// Two instances: ROWS=2 (full frames) and ROWS=1 (remainder).
module tb_input_byte_sequencer;

  localparam int RB = 34;

  logic        din_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] i_word = '0;
  logic        i_word_vld = 1'b0;

  logic       rdy_a, vld_a, sw_a, fd_a, busy_a;
  logic [7:0] d_a;
  logic [1:0] rc_a;
  logic       rdy_b, vld_b, sw_b, fd_b, busy_b;
  logic [7:0] d_b;
  logic [0:0] rc_b;

  always #5 din_clk = ~din_clk;

  input_byte_sequencer #(.ROW_BYTES(RB), .ROWS(2)) u_a (
    .din_clk(din_clk), .rst_n(rst_n), .en(en),
    .i_start(start_a), .i_word(i_word),
    .i_word_vld(i_word_vld), .o_word_rdy(rdy_a),
    .o_data_din(d_a), .o_data_din_vld(vld_a),
    .o_switch_pingpong(sw_a), .o_busy(busy_a),
    .o_frame_done(fd_a), .o_row_cnt(rc_a)
  );

  input_byte_sequencer #(.ROW_BYTES(RB), .ROWS(1)) u_b (
    .din_clk(din_clk), .rst_n(rst_n), .en(en),
    .i_start(start_b), .i_word(i_word),
    .i_word_vld(i_word_vld), .o_word_rdy(rdy_b),
    .o_data_din(d_b), .o_data_din_vld(vld_b),
    .o_switch_pingpong(sw_b), .o_busy(busy_b),
    .o_frame_done(fd_b), .o_row_cnt(rc_b)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  int sel = 0, rate = 100, cur_rows = 2, cur_rem = 0;
  int widx = 0, nbytes = 0, row_bytes = 0;
  int nsw = 0, nfd = 0, cc = 0, sc = 0;
  int first_cc = 0, last_cc = 0;
  int drop1 = 0, drop2 = 0, rst_at = 0, start_at = 0;
  int en_left = 0;
  bit src_on = 0, took = 0, chk_gap = 0;
  bit en_edge = 1, rst_edge = 1;
  bit prev_fd = 0, prev_sw = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic mon();
    logic r, v, s, f, b;
    logic [7:0] d;
    logic [1:0] rc;
    logic [31:0] w;
    cc++;
    if (sel == 0) begin
      r = rdy_a; v = vld_a; s = sw_a; f = fd_a;
      b = busy_a; d = d_a; rc = rc_a;
    end else begin
      r = rdy_b; v = vld_b; s = sw_b; f = fd_b;
      b = busy_b; d = d_b; rc = {1'b0, rc_b};
    end
    if (!rst_edge) begin
      check("rst_out", {19'd0, v, s, f, b, rc, d}, 0);
      check("rst_rdy", r, 0);
    end else begin
      if (!en_edge) check("en_quiet", {v, s, f}, 0);
      if (!en) check("en_rdy", r, 0);
      if (prev_fd) check("busy_fall", b, 0);
    end
    if (v) begin
      check("byte_q", q.size() > 0, 1);
      if (q.size() > 0) check("byte", d, q.pop_front());
      nbytes++;
      row_bytes++;
      if (chk_gap) begin
        if (nbytes == 1) begin
          check("lat", cc - sc, 3);
          first_cc = cc;
        end
        if (nbytes == RB) begin
          check("row_gap", cc - first_cc, RB - 1);
          last_cc = cc;
        end
        if (nbytes == RB + 1)
          check("row2_start", cc - last_cc, 2);
      end
      if (nbytes == drop1 || nbytes == drop2) begin
        en = 1'b0;
        en_left = 5;
      end
      if (nbytes == start_at) begin
        if (sel == 0) start_a = 1'b1;
        else start_b = 1'b1;
      end
      if (nbytes == rst_at) rst_n = 1'b0;
    end
    if (s) begin
      check("sw_vld", v, 0);
      check("sw_row", row_bytes, RB);
      row_bytes = 0;
      nsw++;
    end
    if (f) begin
      check("fd_after_sw", prev_sw, 1);
      check("fd_rc", rc, cur_rows);
      check("fd_rem", q.size(), cur_rem);
      nfd++;
    end
    prev_fd = f;
    prev_sw = s;
    took = i_word_vld && r && en && rst_n;
    if (took) begin
      w = word(widx);
      for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
    end
  endtask

  task automatic cyc();
    @(negedge din_clk);
    mon();
    @(posedge din_clk);
    en_edge = en;
    rst_edge = rst_n;
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    if (took) widx++;
    took = 0;
    if (en_left > 0) begin
      en_left--;
      if (en_left == 0) en = 1'b1;
    end
    i_word = word(widx);
    i_word_vld = src_on && ($urandom_range(99) < rate);
  endtask

  task automatic run_frame(input int s, input int rt,
                           input int rows, input int rem,
                           input int budget);
    int n;
    sel = s; rate = rt; cur_rows = rows; cur_rem = rem;
    q.delete();
    widx = 0; nbytes = 0; row_bytes = 0;
    nsw = 0; nfd = 0; src_on = 1;
    chk_gap = (rt == 100) && (drop1 == 0);
    i_word = word(0);
    i_word_vld = $urandom_range(99) < rate;
    if (s == 0) start_a = 1'b1;
    else start_b = 1'b1;
    cyc();
    sc = cc;
    check("busy_up", (s == 0) ? busy_a : busy_b, 1);
    n = 0;
    while (nfd == 0 && rst_n && n < budget) begin
      cyc();
      n++;
    end
    if (rst_n) check("timeout", n < budget, 1);
  endtask

  task automatic full_checks();
    check("words", widx, 17);
    check("bytes", nbytes, 68);
    check("switches", nsw, 2);
    check("frame_done", nfd, 1);
  endtask

  initial begin
    @(posedge din_clk);
    #1;
    rst_edge = 0;
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom);
      start_a = 1'($urandom);
      start_b = 1'($urandom);
      i_word = $urandom;
      cyc();
    end
    rst_n = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    check("idle_busy", busy_a, 0);
    check("idle_rdy", rdy_a, 0);

    run_frame(0, 100, 2, 0, 300);
    full_checks();
    cyc(); cyc();
    src_on = 0;

    run_frame(1, 100, 1, 2, 200);
    check("rem_words", widx, 9);
    check("rem_bytes", nbytes, 34);
    check("rem_sw", nsw, 1);
    for (int i = 0; i < 4; i++) cyc();
    check("rem_no_10th", widx, 9);
    src_on = 0;

    run_frame(0, 50, 2, 0, 800);
    full_checks();
    cyc(); cyc();
    src_on = 0;

    drop1 = 17; drop2 = 34; start_at = 10;
    run_frame(0, 100, 2, 0, 400);
    full_checks();
    drop1 = 0; drop2 = 0;
    cyc(); cyc();
    src_on = 0;

    rst_at = 22;
    run_frame(0, 100, 2, 0, 300);
    rst_at = 0; start_at = 0;
    check("rst_mid_bytes", nbytes, 22);
    cyc();
    check("rst_no_sw", nsw, 0);
    check("rst_no_fd", nfd, 0);
    rst_n = 1'b1;
    cyc();
    run_frame(0, 100, 2, 0, 300);
    full_checks();
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
